// File: rtl/fetch_align_buffer_if.sv
// Fetch-side bus bundle: I-cache request/response, redirect, and the decode handshake.
// The buffer drives through the slave modport; the cache/pipeline environment uses master.
interface fetch_align_buffer_if #(
    parameter int DEPTH         = 8,
    parameter int FETCH_PARCELS = 2
);
    logic                          icache_ren_o;
    logic [29:0]                   icache_addr_o;
    logic                          icache_stall_i;
    logic [16*FETCH_PARCELS-1:0]   icache_rdata_i;
    logic                          redirect_i;
    logic [31:0]                   redirect_pc_i;
    logic                          instr_valid_o;
    logic [31:0]                   instr_o;
    logic                          instr_is_c_o;
    logic [31:0]                   instr_pc_o;
    logic                          instr_ready_i;
    logic [$clog2(DEPTH):0]        buf_count_o;

    modport slave (
        output icache_ren_o, icache_addr_o,
        input  icache_stall_i, icache_rdata_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, instr_is_c_o, instr_pc_o,
        input  instr_ready_i,
        output buf_count_o
    );

    modport master (
        input  icache_ren_o, icache_addr_o,
        output icache_stall_i, icache_rdata_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, instr_is_c_o, instr_pc_o,
        output instr_ready_i,
        input  buf_count_o
    );
endinterface

// File: rtl/fetch_align_buffer.sv
// RV32IC fetch front end: block fetches land in a circular parcel buffer and are
// realigned into whole 16/32-bit instructions tagged with their PC.
module fetch_align_buffer #(
    parameter int          DEPTH         = 8,
    parameter int          FETCH_PARCELS = 2,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          SWAP_BYTES    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    fetch_align_buffer_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int OFFW = $clog2(FETCH_PARCELS);
    localparam int FW   = 16 * FETCH_PARCELS;
    localparam logic [31:0] BLK_MASK = ~(32'(2 * FETCH_PARCELS) - 32'd1);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_reg;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     out_pc_reg;
    logic [OFFW-1:0] drop_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [15:0]     buf_mem [DEPTH];

    logic [FW-1:0]              fetch_data;
    logic [15:0]                parcel   [FETCH_PARCELS];
    logic [PW-1:0]              slot_idx [FETCH_PARCELS];
    logic [FETCH_PARCELS-1:0]   slot_we;

    logic          ren;
    logic          accept;
    logic          pop;
    logic          valid;
    logic          head_is32;
    logic [15:0]   p0;
    logic [15:0]   p1;
    logic [CW-1:0] n_written;
    logic [CW-1:0] n_popped;

    // Byte order is fixed per 32-bit word of the cache port.
    for (genvar gi = 0; gi < FETCH_PARCELS / 2; gi++) begin : g_word
        logic [31:0] raw_word;
        assign raw_word = bus.icache_rdata_i[32*gi +: 32];
        assign fetch_data[32*gi +: 32] = SWAP_BYTES
            ? {raw_word[7:0], raw_word[15:8], raw_word[23:16], raw_word[31:24]}
            : raw_word;
    end

    // Parcels below drop belong to the bytes before the fetch target and are skipped,
    // so the kept parcels pack contiguously from wr_ptr.
    for (genvar gi = 0; gi < FETCH_PARCELS; gi++) begin : g_slot
        assign parcel[gi]   = fetch_data[16*gi +: 16];
        assign slot_idx[gi] = wr_ptr_reg + PW'(gi) - PW'(drop_reg);
        assign slot_we[gi]  = accept & (drop_reg <= OFFW'(gi));
    end

    always_comb begin
        p0        = buf_mem[rd_ptr_reg];
        p1        = buf_mem[rd_ptr_reg + PW'(1)];
        head_is32 = (p0[1:0] == 2'b11);
        valid     = head_is32 ? (count_reg >= CW'(2)) : (count_reg != '0);
        ren       = (state_reg == RUN)
                  & ((CW'(DEPTH) - count_reg) >= CW'(FETCH_PARCELS))
                  & ~bus.redirect_i;
        accept    = ren & ~bus.icache_stall_i;
        pop       = valid & bus.instr_ready_i & ~bus.redirect_i;
        n_written = accept ? (CW'(FETCH_PARCELS) - CW'(drop_reg)) : '0;
        n_popped  = pop ? (head_is32 ? CW'(2) : CW'(1)) : '0;
    end

    // Output data is gated by valid so stale or never-written slots never leak out.
    assign bus.icache_ren_o  = ren;
    assign bus.icache_addr_o = fetch_pc_reg[31:2];
    assign bus.instr_valid_o = valid;
    assign bus.instr_o       = valid ? (head_is32 ? {p1, p0} : {16'h0000, p0}) : 32'h0;
    assign bus.instr_is_c_o  = valid & ~head_is32;
    assign bus.instr_pc_o    = out_pc_reg;
    assign bus.buf_count_o   = count_reg;

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_PARCELS; i++) begin
            if (slot_we[i]) begin
                buf_mem[slot_idx[i]] <= parcel[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BOOT;
            fetch_pc_reg <= RESET_PC & BLK_MASK;
            drop_reg     <= RESET_PC[OFFW:1];
            out_pc_reg   <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (state_reg == BOOT) begin
                state_reg <= RUN;
            end
            if (bus.redirect_i) begin
                fetch_pc_reg <= bus.redirect_pc_i & BLK_MASK;
                drop_reg     <= bus.redirect_pc_i[OFFW:1];
                out_pc_reg   <= bus.redirect_pc_i & ~32'd1;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                count_reg    <= '0;
            end else begin
                if (accept) begin
                    wr_ptr_reg   <= wr_ptr_reg + PW'(FETCH_PARCELS) - PW'(drop_reg);
                    drop_reg     <= '0;
                    fetch_pc_reg <= fetch_pc_reg + 32'(2 * FETCH_PARCELS);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + n_popped[PW-1:0];
                    out_pc_reg <= out_pc_reg + (head_is32 ? 32'd4 : 32'd2);
                end
                count_reg <= count_reg + n_written - n_popped;
            end
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for two fetch buffer configurations (2-parcel swapped, 4-parcel little-endian)
// sharing one halfword memory image, plus a memory-walk model under random ready/stall.
module tb_fetch_align_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_align_buffer_if #(.DEPTH(8), .FETCH_PARCELS(2)) bus_a ();
    fetch_align_buffer_if #(.DEPTH(8), .FETCH_PARCELS(4)) bus_b ();

    fetch_align_buffer #(.DEPTH(8), .FETCH_PARCELS(2), .RESET_PC(32'h0), .SWAP_BYTES(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    fetch_align_buffer #(.DEPTH(8), .FETCH_PARCELS(4), .RESET_PC(32'h0), .SWAP_BYTES(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    logic [15:0] mem16 [512];
    logic [8:0]  hw_a, hw_b;
    logic [31:0] word_a;

    // Cache model: A sees each 32-bit word byte-reversed, B sees plain little-endian.
    always_comb begin
        hw_a   = {bus_a.icache_addr_o[7:0], 1'b0};
        word_a = {mem16[hw_a + 9'd1], mem16[hw_a]};
        hw_b   = {bus_b.icache_addr_o[7:0], 1'b0};
    end
    assign bus_a.icache_rdata_i = {word_a[7:0], word_a[15:8], word_a[23:16], word_a[31:24]};
    assign bus_b.icache_rdata_i = {mem16[hw_b + 9'd3], mem16[hw_b + 9'd2], mem16[hw_b + 9'd1], mem16[hw_b]};

    int   total = 0;
    int   bad   = 0;
    bit   sel   = 1'b0;
    bit   ready_cur = 1'b0;

    logic        o_valid, o_c, o_ren;
    logic [31:0] o_instr, o_pc;
    logic [29:0] o_addr;
    logic [3:0]  o_count;

    always_comb begin
        if (sel) begin
            o_valid = bus_b.instr_valid_o; o_c = bus_b.instr_is_c_o; o_ren = bus_b.icache_ren_o;
            o_instr = bus_b.instr_o; o_pc = bus_b.instr_pc_o; o_addr = bus_b.icache_addr_o;
            o_count = bus_b.buf_count_o;
        end else begin
            o_valid = bus_a.instr_valid_o; o_c = bus_a.instr_is_c_o; o_ren = bus_a.icache_ren_o;
            o_instr = bus_a.instr_o; o_pc = bus_a.instr_pc_o; o_addr = bus_a.icache_addr_o;
            o_count = bus_a.buf_count_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit r);
        ready_cur = r;
        if (sel) bus_b.instr_ready_i = r; else bus_a.instr_ready_i = r;
    endtask

    task automatic set_stall(input bit s);
        if (sel) bus_b.icache_stall_i = s; else bus_a.icache_stall_i = s;
    endtask

    task automatic redirect(input string tag, input logic [31:0] pc);
        if (sel) begin bus_b.redirect_i = 1'b1; bus_b.redirect_pc_i = pc; end
        else     begin bus_a.redirect_i = 1'b1; bus_a.redirect_pc_i = pc; end
        #1;
        chk({tag, ".redir_ren"}, 32'(o_ren), 32'd0);
        @(posedge clk);
        #1;
        if (sel) bus_b.redirect_i = 1'b0; else bus_a.redirect_i = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the next instruction, check it, then pop it with a one-cycle ready.
    task automatic expect_instr(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        int n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".pc"}, o_pc, pc);
        chk({tag, ".instr"}, o_instr, ins);
        chk({tag, ".is_c"}, 32'(o_c), 32'(ins[1:0] != 2'b11));
        $display("instr %s pc=%h instr=%h is_c=%0d", tag, o_pc, o_instr, o_c);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
    endtask

    // Reference: walk the memory image from start, sizing each instruction by its low bits.
    task automatic random_run(input string tag, input logic [31:0] start, input int n_target);
        logic [31:0] mpc = start;
        logic [31:0] exp;
        logic [8:0]  hw;
        int          n_instr = 0;
        int          cyc = 0;
        redirect({tag, ".start"}, start);
        while (n_instr < n_target && cyc < 4000) begin
            set_ready(1'($urandom_range(0, 1)));
            set_stall($urandom_range(0, 3) == 0);
            #1;
            if (o_valid && ready_cur) begin
                hw = mpc[9:1];
                if (mem16[hw][1:0] == 2'b11) exp = {mem16[hw + 9'd1], mem16[hw]};
                else                          exp = {16'h0000, mem16[hw]};
                chk({tag, ".pc"}, o_pc, mpc);
                chk({tag, ".instr"}, o_instr, exp);
                mpc = mpc + ((exp[1:0] == 2'b11) ? 32'd4 : 32'd2);
                n_instr++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".count"}, 32'(n_instr), 32'(n_target));
        $display("random %s instrs=%0d cycles=%0d", tag, n_instr, cyc);
        set_ready(1'b0);
        set_stall(1'b0);
    endtask

    logic [31:0] tbl_pc  [8] = '{32'h10, 32'h12, 32'h16, 32'h18, 32'h1C, 32'h1E, 32'h20, 32'h24};
    logic [31:0] tbl_ins [8] = '{32'h4505, 32'h00100093, 32'h0505, 32'h00200113,
                                 32'h0001, 32'h8082, 32'h00300193, 32'h4505};
    logic [31:0] tb_pc   [9] = '{32'h1C, 32'h1E, 32'h20, 32'h24, 32'h26, 32'h28, 32'h2A, 32'h2C, 32'h2E};
    logic [31:0] tb_ins  [9] = '{32'h0001, 32'h8082, 32'h00300193, 32'h4505,
                                 32'h0001, 32'h0001, 32'h0001, 32'h0001, 32'h0001};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 512; i++) mem16[i] = 16'h0001;
        for (int i = 256; i < 512; i++) begin
            r = $urandom;
            mem16[i] = {r[15:2], r[16] ? 2'b11 : 2'b01};
        end
        mem16[0] = 16'h0505; mem16[1] = 16'h4505; mem16[2] = 16'h0093; mem16[3] = 16'h0010;
        foreach (tbl_ins[i]) begin
            mem16[tbl_pc[i][8:1]] = tbl_ins[i][15:0];
            if (tbl_ins[i][1:0] == 2'b11) mem16[tbl_pc[i][8:1] + 8'd1] = tbl_ins[i][31:16];
        end
        mem16[128] = 16'h0093; mem16[129] = 16'h0010; mem16[130] = 16'h4505;

        bus_a.icache_stall_i = 1'b0; bus_a.redirect_i = 1'b0; bus_a.redirect_pc_i = '0; bus_a.instr_ready_i = 1'b0;
        bus_b.icache_stall_i = 1'b0; bus_b.redirect_i = 1'b0; bus_b.redirect_pc_i = '0; bus_b.instr_ready_i = 1'b0;

        // Reset values on both instances.
        tick(); tick();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst.ren", 32'(o_ren), 32'd0);
            chk("rst.valid", 32'(o_valid), 32'd0);
            chk("rst.instr", o_instr, 32'd0);
            chk("rst.is_c", 32'(o_c), 32'd0);
            chk("rst.pc", o_pc, 32'd0);
            chk("rst.count", 32'(o_count), 32'd0);
        end
        sel = 1'b0;

        // Boot: one idle cycle, first valid two edges after reset release.
        rst = 1'b0;
        #1;
        chk("boot.ren", 32'(o_ren), 32'd0);
        tick();
        chk("run.ren", 32'(o_ren), 32'd1);
        chk("run.addr", 32'(o_addr), 32'd0);
        chk("run.valid_early", 32'(o_valid), 32'd0);
        tick();
        chk("run.valid", 32'(o_valid), 32'd1);
        expect_instr("seq0", 32'h0, 32'h0505);
        expect_instr("seq1", 32'h2, 32'h4505);
        expect_instr("seq2", 32'h4, 32'h00100093);

        // Straddle: 32-bit instruction at 0x6 split across two blocks.
        mem16[3] = 16'h0113; mem16[4] = 16'h0020; mem16[5] = 16'h0505;
        redirect("strad", 32'h6);
        chk("strad.count0", 32'(o_count), 32'd0);
        chk("strad.pc0", o_pc, 32'h6);
        chk("strad.addr", 32'(o_addr), 32'd1);
        tick();
        chk("strad.count1", 32'(o_count), 32'd1);
        chk("strad.valid1", 32'(o_valid), 32'd0);
        expect_instr("strad.i0", 32'h6, 32'h00200113);
        expect_instr("strad.i1", 32'hA, 32'h0505);

        // Backpressure until full, then drain in order across the refill.
        redirect("full", 32'h10);
        repeat (6) tick();
        chk("full.count", 32'(o_count), 32'd8);
        chk("full.ren", 32'(o_ren), 32'd0);
        chk("full.instr", o_instr, 32'h4505);
        chk("full.pc", o_pc, 32'h10);
        repeat (5) tick();
        chk("full.instr_hold", o_instr, 32'h4505);
        chk("full.pc_hold", o_pc, 32'h10);
        chk("full.count_hold", 32'(o_count), 32'd8);
        foreach (tbl_pc[i]) expect_instr($sformatf("drain%0d", i), tbl_pc[i], tbl_ins[i]);

        // Redirect during a long stall: stalled request abandoned, new address held.
        set_stall(1'b1);
        tick(); tick();
        redirect("stall", 32'h100);
        chk("stall.addr", 32'(o_addr), 32'h40);
        chk("stall.ren", 32'(o_ren), 32'd1);
        chk("stall.count", 32'(o_count), 32'd0);
        tick();
        chk("stall.addr_hold", 32'(o_addr), 32'h40);
        chk("stall.count_hold", 32'(o_count), 32'd0);
        chk("stall.valid", 32'(o_valid), 32'd0);
        tick();
        set_stall(1'b0);
        expect_instr("stall.i0", 32'h100, 32'h00100093);
        expect_instr("stall.i1", 32'h104, 32'h4505);

        random_run("randA", 32'h200, 300);

        // Four-parcel, little-endian instance: redirect with drop=2 and pointer wrap.
        sel = 1'b1;
        redirect("wide", 32'h1C);
        chk("wide.addr", 32'(o_addr), 32'd6);
        chk("wide.pc", o_pc, 32'h1C);
        tick();
        chk("wide.count", 32'(o_count), 32'd2);
        foreach (tb_pc[i]) expect_instr($sformatf("wide%0d", i), tb_pc[i], tb_ins[i]);

        random_run("randB", 32'h202, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
